// File: rtl/controle_multiciclo.sv
// controle_multiciclo
// Moore control unit for the multicycle RV32I datapath. The opcode held in
// IR selects the instruction path; every datapath enable and mux select is a
// pure function of the current state and the memory wait counter.
//
// Parameters
//   MEM_LAT  extra cycles FETCH and LW_MEM hold, to cover RAM latency (0..15)
//   CNT_W    width of the retired-instruction counter
// Ports
//   clockCPU        CPU clock, rising edge
//   reset           asynchronous, active-high
//   iOpcode         IR[6:0]
//   oEscreveIR      IR write enable
//   oEscrevePCBack  PCBack <= PC
//   oEscrevePC      unconditional PC write
//   oEscrevePCCond  PC write qualified by branch comparison
//   oOrigPC         PC source: 0 SaidaULA, 1 ALUOut
//   oIouD           memory address: 0 PC, 1 ALUOut
//   oMemWrite       memory write
//   oMDRWrite       MDR write enable
//   oOrigAULA       ALU A: 0 PC, 1 rs1, 2 PCBack
//   oOrigBULA       ALU B: 0 rs2, 1 const 4, 2 Imm
//   oALUOp          00 add, 01 sub/compare, 10 funct decode
//   oMem2Reg        write-back: 0 ALUOut, 1 MDR, 2 PC, 3 Imm
//   oEscreveReg     register file write
//   oIlegal         illegal-opcode trap flag
//   oEstado         current state code
//   oRetired        retired-instruction count (wraps)
module controle_multiciclo #(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 32
) (
  input  logic             clockCPU,
  input  logic             reset,
  input  logic [6:0]       iOpcode,
  output logic             oEscreveIR,
  output logic             oEscrevePCBack,
  output logic             oEscrevePC,
  output logic             oEscrevePCCond,
  output logic             oOrigPC,
  output logic             oIouD,
  output logic             oMemWrite,
  output logic             oMDRWrite,
  output logic [1:0]       oOrigAULA,
  output logic [1:0]       oOrigBULA,
  output logic [1:0]       oALUOp,
  output logic [1:0]       oMem2Reg,
  output logic             oEscreveReg,
  output logic             oIlegal,
  output logic [3:0]       oEstado,
  output logic [CNT_W-1:0] oRetired
);

  localparam logic [3:0] ST_FETCH    = 4'd0;
  localparam logic [3:0] ST_DECODE   = 4'd1;
  localparam logic [3:0] ST_MEM_ADDR = 4'd2;
  localparam logic [3:0] ST_LW_MEM   = 4'd3;
  localparam logic [3:0] ST_LW_WB    = 4'd4;
  localparam logic [3:0] ST_SW_MEM   = 4'd5;
  localparam logic [3:0] ST_R_EXEC   = 4'd6;
  localparam logic [3:0] ST_ALU_WB   = 4'd7;
  localparam logic [3:0] ST_BRANCH   = 4'd8;
  localparam logic [3:0] ST_JAL      = 4'd9;
  localparam logic [3:0] ST_JALR     = 4'd10;
  localparam logic [3:0] ST_LUI      = 4'd11;
  localparam logic [3:0] ST_I_EXEC   = 4'd12;
  localparam logic [3:0] ST_AUIPC    = 4'd13;
  localparam logic [3:0] ST_ILLEGAL  = 4'd15;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0]       LAT = 4'(MEM_LAT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [3:0]       estado_q, estado_d;
  logic [3:0]       wc_q, wc_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic             last_wait;

  // Final cycle of a FETCH / LW_MEM hold.
  assign last_wait = (wc_q == LAT);

  always_ff @(posedge clockCPU or posedge reset) begin
    if (reset) begin
      estado_q <= ST_FETCH;
      wc_q     <= '0;
      ret_q    <= '0;
    end else begin
      estado_q <= estado_d;
      wc_q     <= wc_d;
      ret_q    <= ret_d;
    end
  end

  // Next state. wc defaults to 0 so every transition clears it; it only
  // counts while a wait state holds.
  always_comb begin
    estado_d = estado_q;
    wc_d     = '0;
    ret_d    = ret_q;
    case (estado_q)
      ST_FETCH: begin
        if (last_wait) estado_d = ST_DECODE;
        else           wc_d     = wc_q + 4'd1;
      end
      ST_DECODE: begin
        case (iOpcode)
          OP_R:              estado_d = ST_R_EXEC;
          OP_I:              estado_d = ST_I_EXEC;
          OP_LOAD, OP_STORE: estado_d = ST_MEM_ADDR;
          OP_BRANCH:         estado_d = ST_BRANCH;
          OP_JAL:            estado_d = ST_JAL;
          OP_JALR:           estado_d = ST_JALR;
          OP_LUI:            estado_d = ST_LUI;
          OP_AUIPC:          estado_d = ST_AUIPC;
          default:           estado_d = ST_ILLEGAL;
        endcase
      end
      ST_MEM_ADDR: estado_d = (iOpcode == OP_STORE) ? ST_SW_MEM : ST_LW_MEM;
      ST_LW_MEM: begin
        if (last_wait) estado_d = ST_LW_WB;
        else           wc_d     = wc_q + 4'd1;
      end
      ST_R_EXEC, ST_I_EXEC, ST_AUIPC: estado_d = ST_ALU_WB;
      ST_LW_WB, ST_SW_MEM, ST_ALU_WB, ST_BRANCH,
      ST_JAL, ST_JALR, ST_LUI: begin
        estado_d = ST_FETCH;
        ret_d    = ret_q + ONE;
      end
      ST_ILLEGAL: estado_d = ST_ILLEGAL;
      default:    estado_d = ST_FETCH;
    endcase
  end

  // Raw Moore decode; write enables are gated by reset below.
  logic ir, pcb, pc, pcc, mw, mdr, wreg;

  always_comb begin
    ir        = 1'b0;
    pcb       = 1'b0;
    pc        = 1'b0;
    pcc       = 1'b0;
    mw        = 1'b0;
    mdr       = 1'b0;
    wreg      = 1'b0;
    oOrigPC   = 1'b0;
    oIouD     = 1'b0;
    oOrigAULA = 2'd0;
    oOrigBULA = 2'd0;
    oALUOp    = 2'b00;
    oMem2Reg  = 2'd0;
    oIlegal   = 1'b0;
    case (estado_q)
      ST_FETCH: begin
        oOrigBULA = 2'd1;
        ir        = last_wait;
        pc        = last_wait;
        pcb       = last_wait;
      end
      ST_DECODE: begin
        oOrigAULA = 2'd2;
        oOrigBULA = 2'd2;
      end
      ST_MEM_ADDR: begin
        oOrigAULA = 2'd1;
        oOrigBULA = 2'd2;
      end
      ST_LW_MEM: begin
        oIouD = 1'b1;
        mdr   = last_wait;
      end
      ST_LW_WB: begin
        oMem2Reg = 2'd1;
        wreg     = 1'b1;
      end
      ST_SW_MEM: begin
        oIouD = 1'b1;
        mw    = 1'b1;
      end
      ST_R_EXEC: begin
        oOrigAULA = 2'd1;
        oALUOp    = 2'b10;
      end
      ST_I_EXEC: begin
        oOrigAULA = 2'd1;
        oOrigBULA = 2'd2;
        oALUOp    = 2'b10;
      end
      ST_AUIPC: begin
        oOrigAULA = 2'd2;
        oOrigBULA = 2'd2;
      end
      ST_ALU_WB: wreg = 1'b1;
      ST_BRANCH: begin
        oOrigAULA = 2'd1;
        oALUOp    = 2'b01;
        pcc       = 1'b1;
        oOrigPC   = 1'b1;
      end
      ST_JAL: begin
        oMem2Reg = 2'd2;
        wreg     = 1'b1;
        pc       = 1'b1;
        oOrigPC  = 1'b1;
      end
      ST_JALR: begin
        oOrigAULA = 2'd1;
        oOrigBULA = 2'd2;
        oMem2Reg  = 2'd2;
        wreg      = 1'b1;
        pc        = 1'b1;
      end
      ST_LUI: begin
        oMem2Reg = 2'd3;
        wreg     = 1'b1;
      end
      ST_ILLEGAL: oIlegal = 1'b1;
      default: ;
    endcase
  end

  // Hold every write enable low while reset is asserted, even mid-cycle.
  assign oEscreveIR     = ir   & ~reset;
  assign oEscrevePCBack = pcb  & ~reset;
  assign oEscrevePC     = pc   & ~reset;
  assign oEscrevePCCond = pcc  & ~reset;
  assign oMemWrite      = mw   & ~reset;
  assign oMDRWrite      = mdr  & ~reset;
  assign oEscreveReg    = wreg & ~reset;

  assign oEstado  = estado_q;
  assign oRetired = ret_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
module tb_controle_multiciclo;
  localparam int MEM_LAT = 2;
  localparam int CNT_W   = 4;
  localparam int F       = MEM_LAT + 1;

  typedef struct packed {
    logic ir, pcb, pc, pcc, origpc, iord, mw, mdr;
    logic [1:0] a, b, op, m2r;
    logic wreg, il;
    logic [3:0] st;
  } ctl_t;

  typedef struct packed {
    ctl_t c;
    logic [CNT_W-1:0] ret;
  } exp_t;

  logic clockCPU = 1'b0;
  logic reset;
  logic [6:0] iOpcode;
  logic oEscreveIR, oEscrevePCBack, oEscrevePC, oEscrevePCCond, oOrigPC;
  logic oIouD, oMemWrite, oMDRWrite, oEscreveReg, oIlegal;
  logic [1:0] oOrigAULA, oOrigBULA, oALUOp, oMem2Reg;
  logic [3:0] oEstado;
  logic [CNT_W-1:0] oRetired;

  controle_multiciclo #(.MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) dut (
    .clockCPU(clockCPU), .reset(reset), .iOpcode(iOpcode),
    .oEscreveIR(oEscreveIR), .oEscrevePCBack(oEscrevePCBack),
    .oEscrevePC(oEscrevePC), .oEscrevePCCond(oEscrevePCCond),
    .oOrigPC(oOrigPC), .oIouD(oIouD), .oMemWrite(oMemWrite),
    .oMDRWrite(oMDRWrite), .oOrigAULA(oOrigAULA), .oOrigBULA(oOrigBULA),
    .oALUOp(oALUOp), .oMem2Reg(oMem2Reg), .oEscreveReg(oEscreveReg),
    .oIlegal(oIlegal), .oEstado(oEstado), .oRetired(oRetired)
  );

  always #5 clockCPU = ~clockCPU;

  int checks = 0;
  int errors = 0;
  exp_t q[$];
  logic [CNT_W-1:0] exp_ret;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected controls for one cycle spent in state s; last marks the final
  // cycle of a memory wait.
  function automatic ctl_t ctl(input int s, input bit last);
    ctl_t c = '0;
    c.st = 4'(s);
    case (s)
      0:  begin c.b = 1; c.ir = last; c.pc = last; c.pcb = last; end
      1:  begin c.a = 2; c.b = 2; end
      2:  begin c.a = 1; c.b = 2; end
      3:  begin c.iord = 1; c.mdr = last; end
      4:  begin c.m2r = 1; c.wreg = 1; end
      5:  begin c.iord = 1; c.mw = 1; end
      6:  begin c.a = 1; c.op = 2; end
      7:  c.wreg = 1;
      8:  begin c.a = 1; c.op = 1; c.pcc = 1; c.origpc = 1; end
      9:  begin c.m2r = 2; c.wreg = 1; c.pc = 1; c.origpc = 1; end
      10: begin c.a = 1; c.b = 2; c.m2r = 2; c.wreg = 1; c.pc = 1; end
      11: begin c.m2r = 3; c.wreg = 1; end
      12: begin c.a = 1; c.b = 2; c.op = 2; end
      13: begin c.a = 2; c.b = 2; end
      15: c.il = 1;
      default: ;
    endcase
    return c;
  endfunction

  // Instruction-level model: opcode -> cycle-by-cycle list of expected controls.
  // cut>0 keeps only the first cut cycles (instruction aborted by reset).
  task automatic run_instr(input logic [6:0] op, input int cut);
    ctl_t seq[$];
    bit   retires = 1'b1;
    int   k = 0;
    for (int i = 0; i < F; i++) seq.push_back(ctl(0, i == F-1));
    seq.push_back(ctl(1, 0));
    case (op)
      7'b0110011: begin seq.push_back(ctl(6, 0));  seq.push_back(ctl(7, 0)); end
      7'b0010011: begin seq.push_back(ctl(12, 0)); seq.push_back(ctl(7, 0)); end
      7'b0010111: begin seq.push_back(ctl(13, 0)); seq.push_back(ctl(7, 0)); end
      7'b0000011: begin
        seq.push_back(ctl(2, 0));
        for (int i = 0; i < F; i++) seq.push_back(ctl(3, i == F-1));
        seq.push_back(ctl(4, 0));
      end
      7'b0100011: begin seq.push_back(ctl(2, 0)); seq.push_back(ctl(5, 0)); end
      7'b1100011: seq.push_back(ctl(8, 0));
      7'b1101111: seq.push_back(ctl(9, 0));
      7'b1100111: seq.push_back(ctl(10, 0));
      7'b0110111: seq.push_back(ctl(11, 0));
      default: begin
        retires = 1'b0;
        for (int i = 0; i < 20; i++) seq.push_back(ctl(15, 0));
      end
    endcase
    if (cut > 0) begin
      retires = 1'b0;
      while (seq.size() > cut) void'(seq.pop_back());
    end
    foreach (seq[i]) q.push_back('{c: seq[i], ret: exp_ret});
    if (retires) exp_ret = exp_ret + 1'b1;
    // Opcode is only meaningful in DECODE and MEM_ADDR; scramble it elsewhere.
    while (q.size() > 0) begin
      iOpcode = (k == F || k == F+1) ? op : 7'($urandom);
      @(posedge clockCPU); #1;
      k++;
      if (k > 200) begin
        chk("instr_timeout", 32'(q.size()), 0);
        q.delete();
      end
    end
  endtask

  // Scoreboard monitor: compares one expected cycle per falling edge.
  always @(negedge clockCPU) begin
    if (!reset && q.size() > 0) begin
      exp_t e;
      ctl_t a;
      e = q.pop_front();
      a = '{oEscreveIR, oEscrevePCBack, oEscrevePC, oEscrevePCCond, oOrigPC,
            oIouD, oMemWrite, oMDRWrite, oOrigAULA, oOrigBULA, oALUOp,
            oMem2Reg, oEscreveReg, oIlegal, oEstado};
      chk("ctl", 32'(a), 32'(e.c));
      chk("retired", 32'(oRetired), 32'(e.ret));
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_estado"}, 32'(oEstado), 0);
    chk({tag, "_wen"}, 32'({oEscreveIR, oEscrevePCBack, oEscrevePC, oEscrevePCCond,
                             oMemWrite, oMDRWrite, oEscreveReg}), 0);
    chk({tag, "_ilegal"}, 32'(oIlegal), 0);
    chk({tag, "_retired"}, 32'(oRetired), 0);
  endtask

  task automatic release_reset();
    @(posedge clockCPU); #1;
    reset = 1'b0;
    exp_ret = '0;
  endtask

  logic [6:0] ops [10];

  initial begin
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0110011};
    reset   = 1'b1;
    iOpcode = 7'b0;
    exp_ret = '0;
    #23;
    chk_reset_outputs("por");
    release_reset();

    // One of each instruction class.
    for (int i = 0; i < 9; i++) run_instr(ops[i], 0);

    // Random stream; with a 4-bit counter this wraps at least twice.
    for (int i = 0; i < 40; i++) run_instr(ops[$urandom_range(0, 9)], 0);

    // Reset arriving in the first LW_MEM cycle aborts the load.
    run_instr(7'b0000011, F + 2);
    #1;
    chk("pre_abort_state", 32'(oEstado), 3);
    #1 reset = 1'b1;
    #1 chk_reset_outputs("abort");
    release_reset();
    run_instr(7'b0110011, 0);   // FETCH restarts with a full wait
    run_instr(7'b0110111, 0);

    // Illegal opcode: traps and stays, not counted.
    run_instr(7'b0000000, 0);
    #1;
    chk("ilegal_hold_state", 32'(oEstado), 15);
    chk("ilegal_flag", 32'(oIlegal), 1);
    chk("ilegal_retired", 32'(oRetired), 32'(exp_ret));
    reset = 1'b1;
    #1 chk_reset_outputs("ilegal_exit");
    release_reset();
    run_instr(7'b1100011, 0);
    run_instr(7'b0100011, 0);

    @(negedge clockCPU);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end
endmodule
